// File: rtl/atm_arb_pkg.sv
// Shared types and constants for the ATM session arbiter.
package atm_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [2:0] OP_BALANCE  = 3'd3;
  localparam logic [2:0] OP_WITHDRAW = 3'd4;
  localparam logic [2:0] OP_DEPOSIT  = 3'd5;
  localparam logic [2:0] OP_CHPIN    = 3'd6;

  localparam int OP_W  = 3;
  localparam int ACC_W = 4;
  localparam int PIN_W = 16;
  localparam int AMT_W = 32;
  localparam int N_ACC = 16;

  // Only real ATM operations influence the per-account failure history.
  function automatic logic op_tracked(input logic [OP_W-1:0] op);
    return (op >= OP_BALANCE) && (op <= OP_CHPIN);
  endfunction

endpackage

// File: rtl/atm_session_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
module rr_picker
  import atm_arb_pkg::*;
#(
  parameter int N_TERM = 4,
  localparam int PW = $clog2(N_TERM)
) (
  input  logic [N_TERM-1:0] i_req,
  input  logic [PW-1:0]     i_rr_ptr,
  output logic [N_TERM-1:0] o_win,
  output logic              o_valid
);

  logic [PW-1:0] w_idx;

  // Scan from the pointer and keep the first asserted request.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_TERM; i++) begin
      w_idx = PW'((int'(i_rr_ptr) + i) % N_TERM);
      if (!o_valid && i_req[w_idx]) begin
        o_win[w_idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_session_arbiter.sv
// Shares one ATM transaction core among N_TERM terminals with round-robin
// grants, a fixed-length enable window and per-account failure lockout.
module atm_session_arbiter
  import atm_arb_pkg::*;
#(
  parameter int N_TERM     = 4,
  parameter int TXN_CYCLES = 4,
  parameter int MAX_FAIL   = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_TERM-1:0]       i_req,
  input  logic [N_TERM*OP_W-1:0]  i_op_in,
  input  logic [N_TERM*ACC_W-1:0] i_acc_in,
  input  logic [N_TERM*PIN_W-1:0] i_pin_in,
  input  logic [N_TERM*PIN_W-1:0] i_newpin_in,
  input  logic [N_TERM*AMT_W-1:0] i_amount_in,
  input  logic [N_TERM-1:0]       i_lang_in,
  output logic                    o_core_en,
  output logic [OP_W-1:0]         o_core_op,
  output logic [ACC_W-1:0]        o_core_acc,
  output logic [PIN_W-1:0]        o_core_pin,
  output logic [PIN_W-1:0]        o_core_newpin,
  output logic [AMT_W-1:0]        o_core_amount,
  output logic                    o_core_lang,
  input  logic [AMT_W-1:0]        i_core_balance,
  input  logic                    i_core_success,
  output logic [N_TERM-1:0]       o_grant,
  output logic [N_TERM-1:0]       o_done,
  output logic [AMT_W-1:0]        o_resp_balance,
  output logic                    o_resp_success,
  output logic [N_ACC-1:0]        o_locked
);

  localparam int PW = $clog2(N_TERM);
  localparam int CW = (TXN_CYCLES > 1) ? $clog2(TXN_CYCLES) : 1;
  localparam logic [CW-1:0] RUN_LAST = CW'(TXN_CYCLES - 1);

  state_t         r_state;
  logic [PW-1:0]  r_rr_ptr;
  logic [PW-1:0]  r_win;
  logic [CW-1:0]  r_run_cnt;
  logic [1:0]     r_fail [N_ACC];

  logic [N_TERM-1:0] w_win_oh;
  logic              w_valid;
  logic [PW-1:0]     w_win_idx;
  logic [OP_W-1:0]   w_op;
  logic [ACC_W-1:0]  w_acc;
  logic [PIN_W-1:0]  w_pin;
  logic [PIN_W-1:0]  w_newpin;
  logic [AMT_W-1:0]  w_amount;
  logic              w_lang;
  logic [N_ACC-1:0]  w_locked;

  rr_picker #(.N_TERM(N_TERM)) u_pick (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_win    (w_win_oh),
    .o_valid  (w_valid)
  );

  // One-hot winner to index, remembered for the field mux and pointer update.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_TERM; i++)
      if (w_win_oh[i]) w_win_idx = PW'(i);
  end

  // Select the granted terminal's request fields.
  always_comb begin
    w_op = '0; w_acc = '0; w_pin = '0; w_newpin = '0; w_amount = '0; w_lang = 1'b0;
    for (int i = 0; i < N_TERM; i++) begin
      if (r_win == PW'(i)) begin
        w_op     = i_op_in[i*OP_W +: OP_W];
        w_acc    = i_acc_in[i*ACC_W +: ACC_W];
        w_pin    = i_pin_in[i*PIN_W +: PIN_W];
        w_newpin = i_newpin_in[i*PIN_W +: PIN_W];
        w_amount = i_amount_in[i*AMT_W +: AMT_W];
        w_lang   = i_lang_in[i];
      end
    end
  end

  // An account is locked once its failure count saturates.
  always_comb begin
    w_locked = '0;
    for (int a = 0; a < N_ACC; a++)
      w_locked[a] = (r_fail[a] == 2'(MAX_FAIL));
  end

  assign o_locked = w_locked;

  // Session FSM: arbitrate, latch, run the core window, return the response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_win          <= '0;
      r_run_cnt      <= '0;
      o_grant        <= '0;
      o_done         <= '0;
      o_core_en      <= 1'b0;
      o_core_op      <= '0;
      o_core_acc     <= '0;
      o_core_pin     <= '0;
      o_core_newpin  <= '0;
      o_core_amount  <= '0;
      o_core_lang    <= 1'b0;
      o_resp_balance <= '0;
      o_resp_success <= 1'b0;
      for (int a = 0; a < N_ACC; a++) r_fail[a] <= 2'd0;
    end else begin
      o_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_win   <= w_win_idx;
            o_grant <= w_win_oh;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          o_core_op     <= w_op;
          o_core_acc    <= w_acc;
          o_core_pin    <= w_pin;
          o_core_newpin <= w_newpin;
          o_core_amount <= w_amount;
          o_core_lang   <= w_lang;
          if (w_locked[w_acc]) begin
            // Locked accounts never reach the core; answer a failure at once.
            o_resp_balance <= '0;
            o_resp_success <= 1'b0;
            o_done         <= o_grant;
            r_state        <= S_RESP;
          end else begin
            o_core_en <= 1'b1;
            r_run_cnt <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_run_cnt == RUN_LAST) begin
            o_core_en      <= 1'b0;
            o_resp_balance <= i_core_balance;
            o_resp_success <= i_core_success;
            o_done         <= o_grant;
            r_state        <= S_RESP;
            if (op_tracked(o_core_op)) begin
              if (i_core_success)
                r_fail[o_core_acc] <= 2'd0;
              else if (r_fail[o_core_acc] != 2'(MAX_FAIL))
                r_fail[o_core_acc] <= r_fail[o_core_acc] + 2'd1;
            end
          end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end
        S_RESP: begin
          o_grant  <= '0;
          r_rr_ptr <= (r_win == PW'(N_TERM - 1)) ? '0 : r_win + 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_arbiter.sv
// Scoreboard bench for atm_session_arbiter with a transaction-level model.
module tb_atm_session_arbiter;
  localparam int N = 4;
  localparam int T = 4;
  localparam int M = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [2:0]      f_op   [N];
  logic [3:0]      f_acc  [N];
  logic [15:0]     f_pin  [N];
  logic [15:0]     f_npin [N];
  logic [31:0]     f_amt  [N];
  logic            f_lang [N];
  logic [N*3-1:0]  op_in;
  logic [N*4-1:0]  acc_in;
  logic [N*16-1:0] pin_in, npin_in;
  logic [N*32-1:0] amt_in;
  logic [N-1:0]    lang_in;

  logic        core_en, core_lang, core_success, resp_success;
  logic [2:0]  core_op;
  logic [3:0]  core_acc;
  logic [15:0] core_pin, core_newpin, locked;
  logic [31:0] core_amount, core_balance, resp_balance;
  logic [N-1:0] grant, done;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      op_in[i*3 +: 3]     = f_op[i];
      acc_in[i*4 +: 4]    = f_acc[i];
      pin_in[i*16 +: 16]  = f_pin[i];
      npin_in[i*16 +: 16] = f_npin[i];
      amt_in[i*32 +: 32]  = f_amt[i];
      lang_in[i]          = f_lang[i];
    end
  end

  // Stand-in core: the right PIN for account a is 1233+a; garbage when idle.
  function automatic logic [31:0] bal_fn(input logic [2:0] op, input logic [3:0] acc,
                                         input logic [31:0] amt);
    return amt ^ {acc, 25'd0, op};
  endfunction
  function automatic logic succ_fn(input logic [3:0] acc, input logic [15:0] pin);
    return pin == (16'd1233 + 16'(acc));
  endfunction

  always_comb begin
    core_balance = core_en ? bal_fn(core_op, core_acc, core_amount) : 32'hDEAD_BEEF;
    core_success = core_en && succ_fn(core_acc, core_pin);
  end

  atm_session_arbiter #(.N_TERM(N), .TXN_CYCLES(T), .MAX_FAIL(M)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .i_op_in(op_in), .i_acc_in(acc_in), .i_pin_in(pin_in), .i_newpin_in(npin_in),
    .i_amount_in(amt_in), .i_lang_in(lang_in),
    .o_core_en(core_en), .o_core_op(core_op), .o_core_acc(core_acc),
    .o_core_pin(core_pin), .o_core_newpin(core_newpin), .o_core_amount(core_amount),
    .o_core_lang(core_lang), .i_core_balance(core_balance), .i_core_success(core_success),
    .o_grant(grant), .o_done(done), .o_resp_balance(resp_balance),
    .o_resp_success(resp_success), .o_locked(locked)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_dn    = 0;
  int issue_k = 0;
  int done_cyc[$];
  logic [N-1:0] term_done;

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Transaction-level reference: round-robin order and failure counts.
  typedef struct {
    int          term;
    logic [31:0] bal;
    logic        succ;
    int          en;
    logic [15:0] lk;
  } exp_t;
  exp_t sb[$];
  int m_ptr;
  int m_fail[16];

  function automatic int model_pick(input logic [N-1:0] pend);
    for (int j = 0; j < N; j++)
      if (pend[(m_ptr + j) % N]) return (m_ptr + j) % N;
    return 0;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int a = 0; a < 16; a++) m_fail[a] = 0;
  endtask

  task automatic model_txn(input int i);
    exp_t e;
    int a;
    a = int'(f_acc[i]);
    e.term = i;
    if (m_fail[a] == M) begin
      e.bal = 0; e.succ = 0; e.en = 0;
    end else begin
      e.bal  = bal_fn(f_op[i], f_acc[i], f_amt[i]);
      e.succ = succ_fn(f_acc[i], f_pin[i]);
      e.en   = T;
      if (f_op[i] >= 3 && f_op[i] <= 6)
        m_fail[a] = e.succ ? 0 : ((m_fail[a] < M) ? m_fail[a] + 1 : M);
    end
    for (int b = 0; b < 16; b++) e.lk[b] = (m_fail[b] == M);
    sb.push_back(e);
    m_ptr = (i + 1) % N;
  endtask

  // Monitor: pops the scoreboard whenever a done pulse appears.
  initial begin
    int en_cnt;
    exp_t e;
    en_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) en_cnt = 0;
      else begin
        if (core_en) en_cnt++;
        if (done != '0) begin
          n_dn++;
          done_cyc.push_back(cyc);
          for (int i = 0; i < N; i++) if (done[i]) term_done[i] = 1'b1;
          if (sb.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
          else begin
            e = sb.pop_front();
            chk("done_onehot", 64'(done), 64'd1 << e.term);
            chk("grant_at_done", 64'(grant), 64'd1 << e.term);
            chk("resp_balance", 64'(resp_balance), 64'(e.bal));
            chk("resp_success", 64'(resp_success), 64'(e.succ));
            chk("core_en_cycles", 64'(en_cnt), 64'(e.en));
            chk("locked_vec", 64'(locked), 64'(e.lk));
          end
          en_cnt = 0;
        end
      end
    end
  end

  task automatic set_f(input int i, input logic [2:0] op, input logic [3:0] acc,
                       input logic [15:0] pin, input logic [31:0] amt);
    f_op[i] = op; f_acc[i] = acc; f_pin[i] = pin; f_amt[i] = amt;
    f_npin[i] = 16'($urandom); f_lang[i] = 1'($urandom);
  endtask

  task automatic rand_f(input int i);
    logic [3:0] a;
    a = 4'($urandom_range(0, 3));
    set_f(i, 3'($urandom_range(0, 7)), a,
          ($urandom_range(0, 1) == 1) ? 16'd1233 + 16'(a) : 16'($urandom), $urandom);
  endtask

  // Raise the request set; hold=1 keeps every request up for n_txn grants.
  task automatic run_set(input logic [N-1:0] set, input bit hold, input int n_txn,
                         input bit scramble);
    logic [N-1:0] pend;
    int target;
    pend = set;
    for (int t = 0; t < n_txn; t++) begin
      int w;
      w = model_pick(pend);
      model_txn(w);
      if (!hold) pend[w] = 1'b0;
    end
    term_done = '0;
    target = n_dn + n_txn;
    @(posedge clk); #1;
    req = set;
    issue_k = cyc + 1;
    for (int c = 0; c < n_txn * (T + 3) + 20; c++) begin
      @(posedge clk); #1;
      if (n_dn >= target) break;
      if (!hold) begin
        for (int i = 0; i < N; i++) begin
          if (term_done[i]) req[i] = 1'b0;
          if (scramble && grant[i] && core_en) begin
            req[i] = 1'b0;
            rand_f(i);
          end
        end
      end
    end
    req = '0;
    chk("all_done", 64'(n_dn), 64'(target));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    req = '0;
    term_done = '0;
    for (int i = 0; i < N; i++) set_f(i, 3'd0, 4'd0, 16'd0, 32'd0);
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_core_en", 64'(core_en), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_resp", {31'd0, resp_success, resp_balance}, 64'd0);
    chk("rst_core_fields", {core_op, core_acc, core_pin, core_newpin, core_lang}, 64'd0);
    chk("rst_core_amount", 64'(core_amount), 64'd0);

    // Contention: all held, order 0,1,2,3,0 at TXN+3 spacing
    for (int i = 0; i < N; i++) set_f(i, 3'd5, 4'(8 + i), 16'd1233 + 16'(8 + i), $urandom);
    run_set(4'b1111, 1'b1, 5, 1'b0);
    sz = done_cyc.size();
    chk("contend_first_latency", 64'(done_cyc[sz-5] - issue_k), 64'(T + 1));
    for (int j = 1; j < 5; j++)
      chk("contend_spacing", 64'(done_cyc[sz-5+j] - done_cyc[sz-6+j]), 64'(T + 3));

    // Single request, terminal 0
    set_f(0, 3'd3, 4'd1, 16'd1234, 32'h0001_2345);
    run_set(4'b0001, 1'b0, 1, 1'b0);
    chk("single_latency", 64'(done_cyc[done_cyc.size()-1] - issue_k), 64'(T + 1));

    // Lockout on account 2
    set_f(1, 3'd4, 4'd2, 16'd0, 32'd50);
    repeat (3) run_set(4'b0010, 1'b0, 1, 1'b0);
    chk("locked2_set", 64'(locked[2]), 64'd1);
    run_set(4'b0010, 1'b0, 1, 1'b0);
    chk("locked_latency", 64'(done_cyc[done_cyc.size()-1] - issue_k), 64'd1);

    // Counter clear on success for account 3
    set_f(2, 3'd6, 4'd3, 16'd7, 32'd9);
    repeat (2) run_set(4'b0100, 1'b0, 1, 1'b0);
    f_pin[2] = 16'd1236;
    run_set(4'b0100, 1'b0, 1, 1'b0);
    f_pin[2] = 16'd8;
    repeat (2) run_set(4'b0100, 1'b0, 1, 1'b0);
    chk("locked3_clear", 64'(locked[3]), 64'd0);

    // Reset in the second RUN cycle aborts without done
    set_f(3, 3'd3, 4'd5, 16'd1238, 32'd77);
    @(posedge clk); #1;
    req = 4'b1000;
    for (int c = 0; c < 20 && !core_en; c++) begin @(posedge clk); #1; end
    chk("abort_reached_run", 64'(core_en), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_core_en", 64'(core_en), 64'd0);
    chk("abort_grant", 64'(grant), 64'd0);
    chk("abort_locked", 64'(locked), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (10) @(posedge clk);
    #1;

    // Randomized batches
    for (int b = 0; b < 40; b++) begin
      logic [N-1:0] set;
      int cnt;
      set = 4'($urandom_range(1, 15));
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        rand_f(i);
        if (set[i]) cnt++;
      end
      run_set(set, 1'b0, cnt, 1'b1);
    end

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_session_arbiter.md
# atm_session_arbiter

Shares the single ATM transaction core among `N_TERM` terminals. Each granted request runs as one complete transaction on the core. Requests are granted round-robin, and each request's fields are latched and muxed onto the core. The block holds the core enabled for a fixed window, then captures `balance`/`success` and returns them to the requester. Consecutive failed transactions are counted per account, and the block blocks further core access to an account once the limit is reached.

## Interface
Parameters:
- `N_TERM`, 4, number of terminals (2..8)
- `TXN_CYCLES`, 4, cycles `core_en` is held high per transaction
- `MAX_FAIL`, 3, consecutive failures that lock an account (1..3)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  N_TERM  per-terminal request; held until matching `done`
- `op_in`  in  N_TERM*3  operation code per terminal (3 balance, 4 withdraw, 5 deposit, 6 change PIN)
- `acc_in`  in  N_TERM*4  account number per terminal
- `pin_in`  in  N_TERM*16  PIN per terminal
- `newpin_in`  in  N_TERM*16  new PIN per terminal
- `amount_in`  in  N_TERM*32  amount per terminal
- `lang_in`  in  N_TERM  language select per terminal
- `core_en`  out  1  drives the core's enable input; 0 forces the core to its idle state
- `core_op`, `core_acc`, `core_pin`, `core_newpin`, `core_amount`, `core_lang`  out  3/4/16/16/32/1  latched fields of the granted request
- `core_balance`  in  32  core balance result
- `core_success`  in  1  core success flag
- `grant`  out  N_TERM  one-hot; the terminal currently owning the core
- `done`  out  N_TERM  one-cycle pulse to the owner when its response is valid
- `resp_balance`  out  32  captured balance
- `resp_success`  out  1  captured success
- `locked`  out  16  per-account lock flags

## Operation
- States: IDLE, LOAD, RUN, RESP. Encoding is defined in the package.
- IDLE:
  - `core_en`=0.
  - If any `req` is set, pick the first requester at or after `rr_ptr` (wrapping), then go to LOAD.
- LOAD:
  - Set the winner's `grant`.
  - Latch all of its fields into `core_*` registers.
  - If the account is locked, go to RESP with `resp_success`=0, `resp_balance`=0, and do not enable the core.
  - Otherwise go to RUN.
- RUN:
  - `core_en`=1 for exactly `TXN_CYCLES` cycles, counted by `run_cnt`.
  - On the last RUN cycle, sample `core_balance`/`core_success` into `resp_*`.
- RESP:
  - `done[winner]`=1 for one cycle.
  - `rr_ptr` becomes (winner+1) mod `N_TERM`.
  - Go to IDLE; `grant` clears on exit.
- Fail counters (2 bits × 16 accounts):
  - Updated when entering RESP from RUN, only when `op` is 3..6.
  - Success clears the counter to 0.
  - Failure saturates the increment at `MAX_FAIL`.
  - `locked[a]` = (counter[a] == `MAX_FAIL`).
  - Locked-account responses do not change the counter.
- Dropping `req` mid-transaction has no effect: the transaction completes and `done` still pulses.
- Input fields are sampled only in LOAD; changes after LOAD are ignored.
- An op outside 3..6 is still passed to the core; the response is returned unmodified and does not update the counter.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, all counters=0, `grant`/`done`/`locked`=0, `resp_*`=0, `core_*`=0, `core_en`=0.
- `rst` in any state aborts immediately: the next cycle is IDLE with reset values, and no `done` is issued for the aborted transaction.
- Normal latency: `req` sampled in IDLE at edge k → `grant` at k+1 → `core_en` high over cycles k+2..k+1+`TXN_CYCLES` → `done` at k+2+`TXN_CYCLES`.
- Locked latency: `done` at k+2.
- IDLE always lasts at least one cycle between transactions, so `core_en` drops for at least one cycle. Back-to-back throughput is one transaction per `TXN_CYCLES`+3 cycles.
- Simultaneous requests: the round-robin order decides. A terminal re-requesting right after its own `done` waits behind all other pending requesters.

## Structure
- Package `atm_arb_pkg` holds:
  - state enum
  - op-code constants (`OP_BALANCE`=3, `OP_WITHDRAW`=4, `OP_DEPOSIT`=5, `OP_CHPIN`=6)
  - width constants (ACC 4, PIN 16, AMT 32)
- Sub-module `rr_picker`: combinational; inputs `req` and `rr_ptr`, outputs one-hot winner and `valid`.
- Everything else (FSM, field mux, fail counters) lives in `atm_session_arbiter`.

## Test plan
- Reset: `rst`=1 for 2 cycles, then idle → all outputs 0, `core_en`=0.
- Single request: terminal 0 (acc=1, pin=1234, op=3) → `grant`=0001 at k+1, `core_en` high for 4 cycles, `done[0]` at k+6, `resp_balance` equals the core's value.
- Contention: `req`=1111 held continuously → grant order 0,1,2,3,0; each `done` 7 cycles apart.
- Lockout: acc=2 with wrong PIN ×3 (core_success=0) → `locked[2]`=1. A 4th request → `done` at k+2 with `resp_success`=0 and no `core_en`. Other accounts are unaffected.
- Counter clear: acc=3 fails twice, then succeeds → counter=0; two further failures leave `locked[3]`=0.
- Reset mid-RUN: assert `rst` in the 2nd RUN cycle → next cycle is IDLE, `core_en`=0, `locked` cleared, no `done`.
